// File: rtl/gate_window_ctrl.sv
// Radar gate conditioner: synchronises gate_in and opens a receive window counted in rxstrobe samples.
// Optional macro GATE_TIMESTAMP_EN adds output stamp, the rxstrobe index latched at each window start.
module gate_window_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 gate_in,
   input  logic                 rxstrobe,
   input  logic [CNT_WIDTH-1:0] delay,
   input  logic [CNT_WIDTH-1:0] window_len,
   input  logic                 clear_status,
   output logic                 gate_enable,
   output logic                 window_active,
   output logic [CNT_WIDTH-1:0] sample_count,
   output logic [CNT_WIDTH-1:0] gate_count,
   output logic                 missed_gate
`ifdef GATE_TIMESTAMP_EN
   ,
   output logic [31:0]          stamp
`endif
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DELAY    = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_WAIT_LOW = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   gate_d_r;
   logic                   gate_s;
   logic                   rise_s;
   logic                   accept_s;
   logic                   dly_step_s;
   logic                   samp_step_s;
   logic [CNT_WIDTH-1:0]   dly_cnt_r;
   logic [CNT_WIDTH-1:0]   delay_lat_r;
   logic [CNT_WIDTH-1:0]   len_lat_r;
   logic [CNT_WIDTH-1:0]   dly_next_s;
   logic [CNT_WIDTH-1:0]   samp_next_s;

   assign gate_s      = sync_r[SYNC_STAGES-1];
   assign rise_s      = gate_s & ~gate_d_r;
   assign dly_next_s  = dly_cnt_r + CNT_ONE;
   assign samp_next_s = sample_count + CNT_ONE;

   // Gate synchroniser chain plus the edge-detect delay flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_r   <= {SYNC_STAGES{1'b0}};
         gate_d_r <= 1'b0;
      end else begin
         sync_r   <= {sync_r[SYNC_STAGES-2:0], gate_in};
         gate_d_r <= gate_s;
      end
   end

   // Next-state decode; enable low always wins and returns the FSM to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      dly_step_s  = 1'b0;
      samp_step_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable && rise_s) begin
               accept_s = 1'b1;
               if (delay == CNT_ZERO) begin
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_DELAY;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else if (rxstrobe) begin
               dly_step_s = 1'b1;
               if (dly_next_s == delay_lat_r) begin
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_DELAY;
               end
            end else begin
               state_nxt_s = ST_DELAY;
            end
         end
         ST_ACTIVE: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else if (rxstrobe) begin
               // Follow-gate mode ends on the first strobe that sees the gate low, uncounted.
               if (len_lat_r == CNT_ZERO) begin
                  if (!gate_s) begin
                     state_nxt_s = ST_WAIT_LOW;
                  end else begin
                     samp_step_s = 1'b1;
                  end
               end else begin
                  samp_step_s = 1'b1;
                  if (samp_next_s == len_lat_r) begin
                     state_nxt_s = ST_WAIT_LOW;
                  end else begin
                     state_nxt_s = ST_ACTIVE;
                  end
               end
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         ST_WAIT_LOW: begin
            if (!enable || !gate_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_LOW;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, registered window outputs, latched window parameters and the per-window counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         gate_enable   <= 1'b0;
         window_active <= 1'b0;
         dly_cnt_r     <= CNT_ZERO;
         delay_lat_r   <= CNT_ZERO;
         len_lat_r     <= CNT_ZERO;
         sample_count  <= CNT_ZERO;
      end else begin
         state_r       <= state_nxt_s;
         gate_enable   <= (state_nxt_s == ST_ACTIVE);
         window_active <= (state_nxt_s == ST_DELAY) || (state_nxt_s == ST_ACTIVE);
         if (accept_s) begin
            delay_lat_r  <= delay;
            len_lat_r    <= window_len;
            dly_cnt_r    <= CNT_ZERO;
            sample_count <= CNT_ZERO;
         end else begin
            if (dly_step_s) begin
               dly_cnt_r <= dly_next_s;
            end
            if (samp_step_s && (sample_count != CNT_MAX)) begin
               sample_count <= samp_next_s;
            end
         end
      end
   end

   // Host-visible status: accepted gate count (wrapping) and the sticky missed-edge flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         gate_count  <= CNT_ZERO;
         missed_gate <= 1'b0;
      end else if (clear_status) begin
         gate_count  <= accept_s ? CNT_ONE : CNT_ZERO;
         missed_gate <= 1'b0;
      end else begin
         if (accept_s) begin
            gate_count <= gate_count + CNT_ONE;
         end
         if (rise_s && (state_r != ST_IDLE)) begin
            missed_gate <= 1'b1;
         end
      end
   end

`ifdef GATE_TIMESTAMP_EN
   logic [31:0] ts_cnt_r;

   // Free-running strobe index, sampled (pre-increment) on each entry to ACTIVE.
   always_ff @(posedge clock) begin
      if (reset) begin
         ts_cnt_r <= 32'd0;
         stamp    <= 32'd0;
      end else begin
         if (rxstrobe) begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
         end
         if ((state_nxt_s == ST_ACTIVE) && (state_r != ST_ACTIVE)) begin
            stamp <= ts_cnt_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gate_window_ctrl.sv
// Self-checking bench for gate_window_ctrl: directed table, corner sequences and a randomized
// run compared every cycle against a behavioural window model.
module tb_gate_window_ctrl;
   localparam int SS = 2;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          reset, enable, gate_in, rxstrobe, clear_status;
   logic [CW-1:0] delay, window_len;
   logic          gate_enable, window_active, missed_gate;
   logic [CW-1:0] sample_count, gate_count;
`ifdef GATE_TIMESTAMP_EN
   logic [31:0]   stamp;
`endif

   gate_window_ctrl #(.SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .gate_in(gate_in), .rxstrobe(rxstrobe),
      .delay(delay), .window_len(window_len), .clear_status(clear_status),
      .gate_enable(gate_enable), .window_active(window_active), .sample_count(sample_count),
      .gate_count(gate_count), .missed_gate(missed_gate)
`ifdef GATE_TIMESTAMP_EN
      , .stamp(stamp)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   bit last_ge;
   int n_strb;

   // Behavioural model: window phases as flags, delay as a countdown of remaining strobes.
   bit [SS-1:0] m_sync;
   bit          m_gd, m_in_delay, m_in_window, m_draining, m_missed;
   int          m_left, m_len, m_sample, m_gcount;
   int unsigned m_ts, m_stamp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      bit gs, rise, busy, accept, was_win;
      gs   = m_sync[SS-1];
      rise = gs && !m_gd;
      if (reset) begin
         m_sync = '0; m_gd = 0; m_in_delay = 0; m_in_window = 0; m_draining = 0;
         m_missed = 0; m_left = 0; m_len = 0; m_sample = 0; m_gcount = 0; m_ts = 0; m_stamp = 0;
         return;
      end
      busy   = m_in_delay || m_in_window || m_draining;
      accept = rise && !busy && enable;
      if (clear_status) begin
         m_gcount = accept ? 1 : 0;
         m_missed = 0;
      end else begin
         if (accept) m_gcount = (m_gcount + 1) % 65536;
         if (rise && busy) m_missed = 1;
      end
      was_win = m_in_window;
      if (!enable) begin
         m_in_delay = 0; m_in_window = 0; m_draining = 0;
      end else if (accept) begin
         m_left = int'(delay); m_len = int'(window_len); m_sample = 0;
         if (delay == 0) m_in_window = 1;
         else m_in_delay = 1;
      end else if (m_in_delay) begin
         if (rxstrobe) begin
            m_left--;
            if (m_left == 0) begin m_in_delay = 0; m_in_window = 1; end
         end
      end else if (m_in_window) begin
         if (rxstrobe) begin
            if (m_len == 0 && !gs) begin
               m_in_window = 0; m_draining = 1;
            end else begin
               if (m_sample < 65535) m_sample++;
               if (m_len != 0 && m_sample == m_len) begin m_in_window = 0; m_draining = 1; end
            end
         end
      end else if (m_draining) begin
         if (!gs) m_draining = 0;
      end
      if (m_in_window && !was_win) m_stamp = m_ts;
      if (rxstrobe) m_ts++;
      m_sync = {m_sync[SS-2:0], gate_in};
      m_gd   = gs;
   endfunction

   task automatic compare_all();
      check("gate_enable", 32'(gate_enable), 32'(m_in_window));
      check("window_active", 32'(window_active), 32'(m_in_delay || m_in_window));
      check("sample_count", 32'(sample_count), 32'(m_sample));
      check("gate_count", 32'(gate_count), 32'(m_gcount));
      check("missed_gate", 32'(missed_gate), 32'(m_missed));
`ifdef GATE_TIMESTAMP_EN
      check("stamp", stamp, m_stamp);
`endif
   endtask

   // One clock: inputs stable from the previous negedge, outputs compared at the next negedge.
   task automatic tick(input bit s);
      rxstrobe = s;
      last_ge  = gate_enable;
      if (s && !reset) n_strb++;
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
      rxstrobe = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0);
   endtask

   typedef struct {
      int dly; int len; int hi; int exp_ge; int exp_first; int exp_sample;
   } row_t;
   row_t rows[5];

   initial begin
      int n_ge, first, k, bound;
      int unsigned s1;
      reset = 1'b1; enable = 1'b1; gate_in = 1'b0; rxstrobe = 1'b0; clear_status = 1'b0;
      delay = '0; window_len = '0; n_strb = 0;

      // {delay, len, gate-high strobes, strobes seen with gate_enable, first such strobe, sample_count}
      rows[0] = '{3, 8, 20, 8, 4, 8};
      rows[1] = '{0, 0, 5, 6, 1, 5};   // the uncounted gate-low strobe still sees gate_enable high
      rows[2] = '{2, 3, 10, 3, 3, 3};
      rows[3] = '{0, 1, 4, 1, 1, 1};
      rows[4] = '{5, 0, 8, 4, 6, 3};

      idle(2);
      reset = 1'b0;
      check("rst_gate_enable", 32'(gate_enable), 32'd0);
      check("rst_gate_count", 32'(gate_count), 32'd0);
      check("rst_sample_count", 32'(sample_count), 32'd0);
      check("rst_missed", 32'(missed_gate), 32'd0);
      idle(4);

      for (int r = 0; r < 5; r++) begin
         delay = CW'(rows[r].dly); window_len = CW'(rows[r].len);
         n_ge = 0; first = 0;
         gate_in = 1'b1;
         idle(7);
         for (k = 1; k <= rows[r].hi; k++) begin
            tick(1'b1);
            if (last_ge) begin n_ge++; if (first == 0) first = k; end
            if (k == rows[r].hi) gate_in = 1'b0;
            idle(7);
         end
         bound = 0;
         while (window_active && bound < 50) begin
            tick(1'b1);
            if (last_ge) begin n_ge++; if (first == 0) first = k; end
            k++; bound++;
            idle(7);
         end
         idle(8);
         check($sformatf("row%0d_ge_strobes", r), n_ge, rows[r].exp_ge);
         check($sformatf("row%0d_first", r), first, rows[r].exp_first);
         check($sformatf("row%0d_sample", r), 32'(sample_count), rows[r].exp_sample);
         check($sformatf("row%0d_gate_count", r), 32'(gate_count), r + 1);
         check($sformatf("row%0d_window_done", r), 32'(window_active), 32'd0);
      end

      // Second edge during a long window is counted as missed and does not disturb it.
      delay = '0; window_len = 16'd100; n_ge = 0;
      gate_in = 1'b1; idle(7);
      repeat (2) begin tick(1'b1); if (last_ge) n_ge++; idle(3); end
      gate_in = 1'b0; idle(6); gate_in = 1'b1; idle(6);
      check("t3_missed", 32'(missed_gate), 32'd1);
      check("t3_gate_count", 32'(gate_count), 32'd6);
      bound = 0;
      while (window_active && bound < 300) begin
         tick(1'b1); if (last_ge) n_ge++; idle(3); bound++;
      end
      check("t3_ge_strobes", n_ge, 32'd100);
      check("t3_sample", 32'(sample_count), 32'd100);
      gate_in = 1'b0; idle(8);
      clear_status = 1'b1; tick(1'b0); clear_status = 1'b0;
      check("t3_clear_missed", 32'(missed_gate), 32'd0);
      check("t3_clear_count", 32'(gate_count), 32'd0);

      // Reset in the middle of an active window, then the still-high gate is accepted afresh.
      delay = '0; window_len = 16'd50;
      gate_in = 1'b1; idle(7);
      repeat (3) begin tick(1'b1); idle(3); end
      check("t4_active", 32'(gate_enable), 32'd1);
      reset = 1'b1; tick(1'b0); reset = 1'b0;
      check("t4_ge_after_reset", 32'(gate_enable), 32'd0);
      check("t4_sample_after_reset", 32'(sample_count), 32'd0);
      check("t4_count_after_reset", 32'(gate_count), 32'd0);
      idle(7);
      check("t4_reaccept_ge", 32'(gate_enable), 32'd1);
      check("t4_reaccept_count", 32'(gate_count), 32'd1);
      gate_in = 1'b0;
      bound = 0;
      while (window_active && bound < 100) begin tick(1'b1); idle(3); bound++; end
      check("t4_window_done", 32'(window_active), 32'd0);
      idle(6);

      // Enable dropped during DELAY, then a fresh edge with delay=2.
      delay = 16'd4; window_len = 16'd3; n_ge = 0;
      gate_in = 1'b1; idle(7);
      repeat (2) begin tick(1'b1); idle(3); end
      enable = 1'b0; tick(1'b0);
      check("t5_disabled_window", 32'(window_active), 32'd0);
      repeat (4) begin tick(1'b1); if (last_ge) n_ge++; idle(3); end
      check("t5_no_ge", n_ge, 32'd0);
      gate_in = 1'b0; idle(6);
      enable = 1'b1; delay = 16'd2; gate_in = 1'b1; idle(7);
      n_ge = 0; first = 0;
      for (k = 1; k <= 8; k++) begin
         tick(1'b1); if (last_ge) begin n_ge++; if (first == 0) first = k; end
         idle(3);
      end
      check("t5_first", first, 32'd3);
      check("t5_ge_strobes", n_ge, 32'd3);
      gate_in = 1'b0; idle(8);

`ifdef GATE_TIMESTAMP_EN
      reset = 1'b1; tick(1'b0); reset = 1'b0; n_strb = 0;
      delay = '0; window_len = 16'd2;
      while (n_strb < 10) begin tick(1'b1); idle(3); end
      gate_in = 1'b1; idle(7);
      check("t6_stamp1", stamp, 32'd10);
      s1 = stamp;
      gate_in = 1'b0;
      while (n_strb < 50) begin tick(1'b1); idle(3); end
      gate_in = 1'b1; idle(7);
      check("t6_stamp2", stamp, 32'd50);
      check("t6_stamp_diff", stamp - s1, 32'd40);
      gate_in = 1'b0;
      repeat (4) begin tick(1'b1); idle(3); end
`endif

      // Randomized traffic, every cycle compared against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) gate_in = ~gate_in;
         if ($urandom_range(0, 79) == 0) enable = ~enable;
         delay        = CW'($urandom_range(0, 3));
         window_len   = CW'($urandom_range(0, 4));
         clear_status = ($urandom_range(0, 49) == 0);
         reset        = ($urandom_range(0, 599) == 0);
         tick($urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
